// File: rtl/idpcm_dc_decoder.sv
// Inverse anchor-based DPCM for quantised DC coefficients, one independent run per Y/Cr/Cb channel.
// One output register with a valid/ready handshake; accepted words appear on the next edge.
module idpcm_dc_decoder #(
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned BLOCK_NUM = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] diff_data,
    input  logic              diff_valid,
    output logic              diff_ready,
    input  logic              flush,
    output logic [DATA_W-1:0] dc_out,
    output logic [1:0]        dc_mode,
    output logic              dc_valid,
    input  logic              dc_ready,
    output logic              dc_last
);

    localparam int unsigned NumCh = 3;
    localparam logic [7:0] LastCnt = 8'(BLOCK_NUM);

    typedef enum logic {StIdle, StRun} state_t;

    state_t            state_q  [NumCh];
    state_t            state_d  [NumCh];
    logic [DATA_W-1:0] anchor_q [NumCh];
    logic [DATA_W-1:0] anchor_d [NumCh];
    logic [7:0]        cnt_q    [NumCh];
    logic [7:0]        cnt_d    [NumCh];

    logic              dc_valid_q, dc_valid_d;
    logic [DATA_W-1:0] dc_out_q, dc_out_d;
    logic [1:0]        dc_mode_q, dc_mode_d;
    logic              dc_last_q, dc_last_d;

    logic              accept;
    logic [DATA_W-1:0] rec_val;
    logic [7:0]        nxt_cnt;
    logic              is_last;

    assign diff_ready = !dc_valid_q || dc_ready;
    assign accept     = diff_valid && diff_ready;

    always_comb begin
        state_d    = state_q;
        anchor_d   = anchor_q;
        cnt_d      = cnt_q;
        dc_valid_d = dc_valid_q && !dc_ready;
        dc_out_d   = dc_out_q;
        dc_mode_d  = dc_mode_q;
        dc_last_d  = dc_last_q;
        rec_val    = '0;
        nxt_cnt    = '0;
        is_last    = 1'b0;

        if (flush) begin
            // Any word accepted alongside flush is swallowed; anchors survive.
            for (int c = 0; c < NumCh; c++) begin
                state_d[c] = StIdle;
                cnt_d[c]   = '0;
            end
        end else if (accept) begin
            for (int c = 0; c < NumCh; c++) begin
                if (mode == 2'(c + 1)) begin
                    if (state_q[c] == StIdle) begin
                        rec_val     = diff_data;
                        anchor_d[c] = diff_data;
                        nxt_cnt     = 8'd1;
                    end else begin
                        rec_val = anchor_q[c] - diff_data;
                        nxt_cnt = cnt_q[c] + 8'd1;
                    end
                    is_last = (nxt_cnt == LastCnt);
                    if (is_last) begin
                        state_d[c] = StIdle;
                        cnt_d[c]   = '0;
                    end else begin
                        state_d[c] = StRun;
                        cnt_d[c]   = nxt_cnt;
                    end
                    dc_valid_d = 1'b1;
                    dc_out_d   = rec_val;
                    dc_mode_d  = mode;
                    dc_last_d  = is_last;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NumCh; c++) begin
                state_q[c]  <= StIdle;
                anchor_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
            dc_valid_q <= 1'b0;
            dc_out_q   <= '0;
            dc_mode_q  <= '0;
            dc_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            anchor_q   <= anchor_d;
            cnt_q      <= cnt_d;
            dc_valid_q <= dc_valid_d;
            dc_out_q   <= dc_out_d;
            dc_mode_q  <= dc_mode_d;
            dc_last_q  <= dc_last_d;
        end
    end

    assign dc_valid = dc_valid_q;
    assign dc_out   = dc_out_q;
    assign dc_mode  = dc_mode_q;
    assign dc_last  = dc_last_q;

endmodule

// File: tb/tb_idpcm_dc_decoder.sv
// Directed bench for idpcm_dc_decoder: hand-computed DC reconstruction, run end, backpressure,
// interleaving, wrap-around, flush and asynchronous reset.
module tb_idpcm_dc_decoder;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mode;
    logic [11:0] diff_data;
    logic        diff_valid;
    logic        diff_ready;
    logic        flush;
    logic [11:0] dc_out;
    logic [1:0]  dc_mode;
    logic        dc_valid;
    logic        dc_ready;
    logic        dc_last;

    int total = 0;
    int bad   = 0;

    idpcm_dc_decoder #(.DATA_W(12), .BLOCK_NUM(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .diff_data  (diff_data),
        .diff_valid (diff_valid),
        .diff_ready (diff_ready),
        .flush      (flush),
        .dc_out     (dc_out),
        .dc_mode    (dc_mode),
        .dc_valid   (dc_valid),
        .dc_ready   (dc_ready),
        .dc_last    (dc_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one word with dc_ready=1 and check the registered result one edge later.
    task automatic xfer(input string tag, input logic [1:0] m, input logic [11:0] d,
                        input logic [11:0] exp_out, input logic exp_last);
        mode       = m;
        diff_data  = d;
        diff_valid = 1'b1;
        #1;
        check({tag, ".rdy"}, 32'(diff_ready), 32'd1);
        @(posedge clk);
        #1;
        diff_valid = 1'b0;
        check({tag, ".vld"}, 32'(dc_valid), 32'd1);
        check({tag, ".out"}, 32'(dc_out), 32'(exp_out));
        check({tag, ".mode"}, 32'(dc_mode), 32'(m));
        check({tag, ".last"}, 32'(dc_last), 32'(exp_last));
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        mode       = 2'b00;
        diff_data  = '0;
        diff_valid = 1'b0;
        flush      = 1'b0;
        dc_ready   = 1'b1;
        #22;
        check("rst.vld", 32'(dc_valid), 32'd0);
        check("rst.out", 32'(dc_out), 32'd0);
        check("rst.mode", 32'(dc_mode), 32'd0);
        check("rst.last", 32'(dc_last), 32'd0);
        check("rst.rdy", 32'(diff_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cr run
        xfer("t1a", 2'b10, 12'd100, 12'd100, 1'b0);
        xfer("t1b", 2'b10, 12'd10, 12'd90, 1'b0);
        xfer("t1c", 2'b10, 12'(-5), 12'd105, 1'b0);

        // Run end at 64 words, 65th starts a fresh run
        do_flush();
        for (int i = 0; i < 64; i++) begin
            xfer($sformatf("t2_%0d", i), 2'b10, (i == 0) ? 12'd7 : 12'd0, 12'd7, i == 63);
        end
        xfer("t2new", 2'b10, 12'd30, 12'd30, 1'b0);

        // Backpressure
        do_flush();
        xfer("t3a", 2'b10, 12'd100, 12'd100, 1'b0);
        diff_data  = 12'd10;
        diff_valid = 1'b1;
        dc_ready   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3.rdy", 32'(diff_ready), 32'd0);
            @(posedge clk);
            #1;
            check("t3.vld", 32'(dc_valid), 32'd1);
            check("t3.hold", 32'(dc_out), 32'd100);
        end
        dc_ready = 1'b1;
        #1;
        check("t3.rel", 32'(diff_ready), 32'd1);
        @(posedge clk);
        #1;
        diff_valid = 1'b0;
        check("t3b.out", 32'(dc_out), 32'd90);
        check("t3b.vld", 32'(dc_valid), 32'd1);
        xfer("t3c", 2'b10, 12'(-5), 12'd105, 1'b0);

        // Interleaved channels
        do_flush();
        xfer("t4y0", 2'b01, 12'd50, 12'd50, 1'b0);
        xfer("t4r0", 2'b10, 12'd20, 12'd20, 1'b0);
        xfer("t4y1", 2'b01, 12'd5, 12'd45, 1'b0);
        xfer("t4r1", 2'b10, 12'(-4), 12'd24, 1'b0);

        // Wrap-around, no saturation
        do_flush();
        xfer("t5a", 2'b11, 12'h7FF, 12'h7FF, 1'b0);
        xfer("t5b", 2'b11, 12'hFFF, 12'h800, 1'b0);
        do_flush();
        xfer("t5c", 2'b11, 12'h800, 12'h800, 1'b0);
        xfer("t5d", 2'b11, 12'd1, 12'h7FF, 1'b0);

        // Invalid mode consumes the word silently
        mode       = 2'b00;
        diff_data  = 12'd77;
        diff_valid = 1'b1;
        @(posedge clk);
        #1;
        diff_valid = 1'b0;
        check("t6.m0", 32'(dc_valid), 32'd0);

        // Flush mid-run restarts Y; a word accepted with flush is dropped
        do_flush();
        xfer("t6y0", 2'b01, 12'd5, 12'd5, 1'b0);
        xfer("t6y1", 2'b01, 12'd1, 12'd4, 1'b0);
        xfer("t6y2", 2'b01, 12'd1, 12'd4, 1'b0);
        mode       = 2'b01;
        diff_data  = 12'd3;
        diff_valid = 1'b1;
        flush      = 1'b1;
        @(posedge clk);
        #1;
        flush      = 1'b0;
        diff_valid = 1'b0;
        check("t6.fldrop", 32'(dc_valid), 32'd0);
        xfer("t6y3", 2'b01, 12'd9, 12'd9, 1'b0);

        // Asynchronous reset with a held output
        xfer("t6r0", 2'b01, 12'd8, 12'd1, 1'b0);
        dc_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6.rstvld", 32'(dc_valid), 32'd0);
        check("t6.rstout", 32'(dc_out), 32'd0);
        #3;
        rst_n    = 1'b1;
        dc_ready = 1'b1;
        @(posedge clk);
        #1;
        xfer("t6raw", 2'b01, 12'd3, 12'd3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
